// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with shared prescaled period counter
//
// Purpose: CHANNELS independent PWM outputs sharing one prescaler and one WIDTH-bit period
// counter. Duty values are written into per-channel pending registers and only take effect
// at the period boundary (counter wrap to 0), so an output never changes duty mid-period.
// Optional macro SERVO_PWM_CLAMP_EN clamps each duty into [pwm_min, pwm_max] at load time,
// with pwm_min taking precedence when the two limits cross.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   div_clk      prescaler terminal count; one tick every div_clk+1 clk cycles
//   wr_en        one-cycle duty write strobe
//   wr_addr      channel index for the write (out-of-range indices are dropped)
//   wr_data      requested duty in ticks
//   ch_enable    per-channel enable, captured at each period boundary
//   pwm_min      lower duty clamp (clamp build only)
//   pwm_max      upper duty clamp (clamp build only)
//   pwm          registered PWM outputs
//   period_start one-cycle pulse in the cycle the period counter becomes 0
//   pending      channel holds a written duty not yet applied
module servo_pwm_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 16,
    localparam int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div_clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [CHANNELS-1:0]  ch_enable,
    input  logic [WIDTH-1:0]     pwm_min,
    input  logic [WIDTH-1:0]     pwm_max,
    output logic [CHANNELS-1:0]  pwm,
    output logic                 period_start,
    output logic [CHANNELS-1:0]  pending
);

    localparam logic [AW:0] CH_LIM = CHANNELS[AW:0];

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [WIDTH-1:0]     cnt;
    logic                 tick;
    logic                 boundary;
    logic                 wr_hit;
    logic [WIDTH-1:0]     pend_val    [CHANNELS];
    logic [WIDTH-1:0]     shadow_duty [CHANNELS];
    logic [WIDTH-1:0]     load_val    [CHANNELS];
    logic [CHANNELS-1:0]  shadow_en;
    logic [CHANNELS-1:0]  pwm_next;
    logic [CHANNELS-1:0]  pending_next;

`ifdef SERVO_PWM_CLAMP_EN
    // Upper limit first, lower limit last, so pwm_min wins when the limits cross.
    function automatic logic [WIDTH-1:0] duty_of(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] hi);
        logic [WIDTH-1:0] t;
        t = (v > hi) ? hi : v;
        return (t < lo) ? lo : t;
    endfunction
`else
    function automatic logic [WIDTH-1:0] duty_of(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] hi);
        logic unused_lim;
        unused_lim = ^{lo, hi};
        return v;
    endfunction
    logic unused_clamp;
    assign unused_clamp = ^{pwm_min, pwm_max};
`endif

    // >= rather than == so a div_clk lowered below the running count still recovers at once.
    assign tick     = (div_cnt >= div_clk);
    assign boundary = tick && (cnt == {WIDTH{1'b1}});
    assign wr_hit   = wr_en && ({1'b0, wr_addr} < CH_LIM);

    always_comb begin
        pending_next = boundary ? '0 : pending;
        if (wr_hit) begin
            // A write on the boundary cycle re-arms pending for the next period.
            pending_next[wr_addr] = 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_next[i] = shadow_en[i] && (cnt < shadow_duty[i]);
            load_val[i] = duty_of(pend_val[i], pwm_min, pwm_max);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
            pending      <= '0;
            shadow_en    <= '0;
            pwm          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pend_val[i]    <= '0;
                shadow_duty[i] <= '0;
            end
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            period_start <= boundary;
            pwm          <= pwm_next;
            pending      <= pending_next;
            if (boundary) begin
                shadow_en <= ch_enable;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (pending[i]) begin
                        // Uses the pre-write pending value; a same-cycle write lands in pend_val.
                        shadow_duty[i] <= load_val[i];
                    end
                end
            end
            if (wr_hit) begin
                pend_val[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - self-checking bench for servo_pwm_multi with a time-based reference model
module tb_servo_pwm_multi;

    localparam int CH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div_clk;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  ch_enable;
    logic [7:0]  pwm_min;
    logic [7:0]  pwm_max;
    logic [2:0]  pwm;
    logic        period_start;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    // Reference model: time t counts clk cycles since the last reset edge.
    int   md = 0;
    int   t  = 0;
    int   mpval [CH];
    int   mduty [CH];
    bit [2:0] mpend, men, mpwm;
    bit   mps;

    servo_pwm_multi #(.CHANNELS(3), .WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .div_clk(div_clk), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ch_enable(ch_enable), .pwm_min(pwm_min), .pwm_max(pwm_max),
        .pwm(pwm), .period_start(period_start), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic int cnt_of(int tt);
        return (tt / (md + 1)) % 256;
    endfunction

    function automatic bit is_bound(int tt);
        return (tt > 0) && (tt % (md + 1) == 0) && ((tt / (md + 1)) % 256 == 0);
    endfunction

    function automatic int clampf(int v);
`ifdef SERVO_PWM_CLAMP_EN
        int r;
        r = (v < int'(pwm_max)) ? v : int'(pwm_max);
        r = (r > int'(pwm_min)) ? r : int'(pwm_min);
        return r;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] rand_duty();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit [2:0] npwm;
        @(posedge clk);
        if (reset) begin
            t = 0; mpend = '0; men = '0; mpwm = '0; mps = 1'b0;
            for (int i = 0; i < CH; i++) begin mpval[i] = 0; mduty[i] = 0; end
        end else begin
            for (int i = 0; i < CH; i++) npwm[i] = men[i] && (cnt_of(t) < mduty[i]);
            t   = t + 1;
            mps = is_bound(t);
            if (mps) begin
                for (int i = 0; i < CH; i++) begin
                    if (mpend[i]) begin mduty[i] = clampf(mpval[i]); mpend[i] = 1'b0; end
                end
                men = ch_enable;
            end
            if (wr_en && int'(wr_addr) < CH) begin
                mpval[wr_addr] = int'(wr_data);
                mpend[wr_addr] = 1'b1;
            end
            mpwm = npwm;
        end
        #1;
        chk("pwm", 32'(pwm), 32'(mpwm));
        chk("period_start", 32'(period_start), 32'(mps));
        chk("pending", 32'(pending), 32'(mpend));
    endtask

    task automatic wr(int a, int d);
        wr_en = 1'b1; wr_addr = 2'(a); wr_data = 8'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic run_rand(int n, bit en_toggle);
        for (int k = 0; k < n; k++) begin
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = rand_duty();
            if (en_toggle && $urandom_range(0, 99) == 0) ch_enable = 3'($urandom_range(0, 7));
            cyc();
        end
        wr_en = 1'b0;
    endtask

    // Counts pwm[ch] high cycles over the full period following the next boundary.
    task automatic measure(int ch, int exp, string tag);
        int hi = 0;
        int p  = 256 * (md + 1);
        for (int k = 0; k < p + 2 && period_start !== 1'b1; k++) cyc();
        chk({tag, "_sync"}, 32'(period_start), 32'd1);
        for (int k = 0; k < p; k++) begin
            cyc();
            hi += int'(pwm[ch]);
        end
        chk(tag, 32'(hi), 32'(exp));
    endtask

    task automatic do_reset(int d, int n);
        reset = 1'b1; div_clk = 16'(d); md = d;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd200;
        repeat (n) cyc();
        wr_en = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; div_clk = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ch_enable = 3'b111; pwm_min = 8'd0; pwm_max = 8'd255;
        do_reset(0, 4);

        wr(0, 64);
        wr(3, 5);
        measure(0, 64, "duty64_div0");

        repeat (10) cyc();
        wr(1, 100);
        repeat (20) cyc();
        wr(1, 20);
        chk("pending1_mid", 32'(pending[1]), 32'd1);
        measure(1, 20, "last_write_wins");

        wr(2, 30);
        for (int k = 0; k < 600 && !is_bound(t + 1); k++) cyc();
        wr(2, 77);
        chk("coincident_ps", 32'(period_start), 32'd1);
        chk("coincident_pending", 32'(pending[2]), 32'd1);
        measure(2, 30, "coincident_old");
        measure(2, 77, "coincident_new");

        run_rand(1500, 1'b1);

        ch_enable = 3'b111;
        for (int k = 0; k < 600 && cnt_of(t) != 120; k++) cyc();
        do_reset(3, 3);
        chk("post_reset_pending", 32'(pending), 32'd0);
        measure(0, 0, "post_reset_duty0");
        wr(0, 10);
        measure(0, 40, "div3_duty10");

        run_rand(2000, 1'b1);

        do_reset(1, 1);
        run_rand(3000, 1'b1);
        ch_enable = 3'b111;
        wr(1, 255);
        measure(1, 510, "duty_max");

`ifdef SERVO_PWM_CLAMP_EN
        pwm_min = 8'd10; pwm_max = 8'd200;
        wr(0, 5);   measure(0, 20,  "clamp_low");
        wr(0, 250); measure(0, 400, "clamp_high");
        wr(0, 50);  measure(0, 100, "clamp_pass");
        pwm_min = 8'd150; pwm_max = 8'd100;
        wr(0, 50);  measure(0, 300, "clamp_crossed");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
